// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control sequencer: opcodes, FSM states,
// decoded instruction classes, write-back select codes and IR field positions.
// No logic; pure constants and types.
package cpu_pkg;

    // Opcodes, IR[15:12]
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_LI   = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_NOP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field bit positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RT_MSB  = 7;
    localparam int RT_LSB  = 4;
    localparam int RS_MSB  = 3;
    localparam int RS_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Register-file write-back mux select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;

    // Sequencer states
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Decoded instruction class; selects the state path through the FSM
    typedef enum logic [3:0] {
        CLS_ALU  = 4'd0,
        CLS_LI   = 4'd1,
        CLS_LD   = 4'd2,
        CLS_ST   = 4'd3,
        CLS_BEQ  = 4'd4,
        CLS_JMP  = 4'd5,
        CLS_NOP  = 4'd6,
        CLS_HALT = 4'd7,
        CLS_ILL  = 4'd8
    } op_cls_t;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control-sequencer bundle: instruction fetch, data-memory handshake and
// register-file / ALU control. master = sequencer, slave = memories/datapath.
// mem_req is a level held until the single-cycle mem_ack pulse.
interface cpu_ctrl_fsm_if #(
    parameter int PC_W  = 10,
    parameter int RF_AW = 4
);
    logic [15:0]      instr_in;    // instruction memory read data
    logic [PC_W-1:0]  addr_instr;  // fetch address (current PC)
    logic             alu_zero;    // ALU result-is-zero
    logic             mem_ack;     // data memory done pulse
    logic             mem_req;     // data memory request level
    logic             mem_we;      // 1 = store, 0 = load
    logic [RF_AW-1:0] addr_src;    // IR[3:0]
    logic [RF_AW-1:0] addr_tmp;    // IR[7:4]
    logic [RF_AW-1:0] addr_dest;   // IR[11:8]
    logic             rf_we;       // register-file write pulse
    logic [1:0]       wb_sel;      // write-back mux select
    logic [7:0]       imm_out;     // zero-extended immediate
    logic [3:0]       alu_op;      // ALU operation code
    logic             halted;      // stopped by HALT
    logic             illegal;     // sticky undefined-opcode flag

    modport master (
        input  instr_in, alu_zero, mem_ack,
        output addr_instr, mem_req, mem_we, addr_src, addr_tmp, addr_dest,
               rf_we, wb_sel, imm_out, alu_op, halted, illegal
    );

    modport slave (
        output instr_in, alu_zero, mem_ack,
        input  addr_instr, mem_req, mem_we, addr_src, addr_tmp, addr_dest,
               rf_we, wb_sel, imm_out, alu_op, halted, illegal
    );
endinterface

// File: rtl/cpu_decoder.sv
// Opcode decoder: maps a 4-bit opcode to instruction class and control fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; stateless.
// Ports: i_op opcode in; o_cls class, o_alu_op, o_wb_sel, o_mem_we, o_illegal out.
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] i_op,
    output op_cls_t    o_cls,
    output logic [3:0] o_alu_op,
    output logic [1:0] o_wb_sel,
    output logic       o_mem_we,
    output logic       o_illegal
);

    always_comb begin
        o_cls     = CLS_NOP;
        o_alu_op  = OP_ADD;
        o_wb_sel  = WB_ALU;
        o_mem_we  = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                o_cls    = CLS_ALU;
                o_alu_op = i_op;
            end
            OP_LI: begin
                o_cls    = CLS_LI;
                o_wb_sel = WB_IMM;
            end
            // Loads and stores use the ALU adder for address formation
            OP_LD: begin
                o_cls    = CLS_LD;
                o_alu_op = OP_ADD;
                o_wb_sel = WB_MEM;
            end
            OP_ST: begin
                o_cls    = CLS_ST;
                o_alu_op = OP_ADD;
                o_mem_we = 1'b1;
            end
            // Branch compares by subtraction and tests alu_zero
            OP_BEQ: begin
                o_cls    = CLS_BEQ;
                o_alu_op = OP_SUB;
            end
            OP_JMP:  o_cls = CLS_JMP;
            OP_NOP:  o_cls = CLS_NOP;
            OP_HALT: o_cls = CLS_HALT;
            default: begin
                o_cls     = CLS_ILL;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: owns PC and IR, decodes and sequences execution.
// Latency: ALU 4, LI 3, LD 5+wait, ST 4+wait, BEQ 3, JMP/NOP 2 cycles.
// Backpressure: stalls in MEM while mem_req is held until mem_ack; no timeout.
// Ports: sys_clk, sys_rst (async active-low) plain; all fetch, memory and
// datapath control signals travel on bus (cpu_ctrl_fsm_if.master).
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int RF_AW = 4
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    cpu_ctrl_fsm_if.master bus
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic            r_mem_req;
    logic            r_mem_we;
    logic            r_rf_we;
    logic [1:0]      r_wb_sel;
    logic [3:0]      r_alu_op;
    logic            r_halted;
    logic            r_illegal;

    logic [3:0]      w_op;
    op_cls_t         w_cls;
    logic [3:0]      w_dec_alu_op;
    logic [1:0]      w_dec_wb_sel;
    logic            w_dec_mem_we;
    logic            w_dec_illegal;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_br_off;
    logic [PC_W-1:0] w_br_tgt;

    // In DECODE the IR is not loaded yet, so decode straight from memory data;
    // in every later state the latched IR is the source.
    assign w_op = (r_state == S_DECODE) ? bus.instr_in[OP_MSB:OP_LSB]
                                        : r_ir[OP_MSB:OP_LSB];

    cpu_decoder u_dec (
        .i_op      (w_op),
        .o_cls     (w_cls),
        .o_alu_op  (w_dec_alu_op),
        .o_wb_sel  (w_dec_wb_sel),
        .o_mem_we  (w_dec_mem_we),
        .o_illegal (w_dec_illegal)
    );

    assign w_pc_inc = r_pc + PC_W'(1);
    // Branch offset lives in the rd field; PC is already incremented in EXEC
    assign w_br_off = {{(PC_W-4){r_ir[RD_MSB]}}, r_ir[RD_MSB:RD_LSB]};
    assign w_br_tgt = r_pc + w_br_off;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_ir      <= {OP_NOP, 12'h000};
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_rf_we   <= 1'b0;
            r_wb_sel  <= WB_ALU;
            r_alu_op  <= OP_ADD;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_state <= S_DECODE;
                end

                S_DECODE: begin
                    r_ir <= bus.instr_in;
                    r_pc <= w_pc_inc;
                    if (w_dec_illegal) begin
                        r_illegal <= 1'b1;
                    end
                    case (w_cls)
                        CLS_ALU, CLS_LD, CLS_ST, CLS_BEQ: begin
                            r_state  <= S_EXEC;
                            r_alu_op <= w_dec_alu_op;
                        end
                        CLS_LI: begin
                            r_state  <= S_WB;
                            r_rf_we  <= 1'b1;
                            r_wb_sel <= w_dec_wb_sel;
                        end
                        CLS_JMP: begin
                            r_state <= S_FETCH;
                            r_pc    <= bus.instr_in[PC_W-1:0];
                        end
                        CLS_HALT: begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                        default: begin
                            // NOP and undefined opcodes simply move on
                            r_state <= S_FETCH;
                        end
                    endcase
                end

                S_EXEC: begin
                    case (w_cls)
                        CLS_BEQ: begin
                            if (bus.alu_zero) begin
                                r_pc <= w_br_tgt;
                            end
                            r_state <= S_FETCH;
                        end
                        CLS_LD, CLS_ST: begin
                            r_state   <= S_MEM;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= w_dec_mem_we;
                        end
                        default: begin
                            r_state  <= S_WB;
                            r_rf_we  <= 1'b1;
                            r_wb_sel <= w_dec_wb_sel;
                        end
                    endcase
                end

                S_MEM: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (w_cls == CLS_LD) begin
                            r_state  <= S_WB;
                            r_rf_we  <= 1'b1;
                            r_wb_sel <= w_dec_wb_sel;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_WB: begin
                    // alu_op is intentionally left untouched so the ALU
                    // result is still valid at the write edge.
                    r_rf_we <= 1'b0;
                    r_state <= S_FETCH;
                end

                S_HALT: begin
                    r_state <= S_HALT;
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.addr_instr = r_pc;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.rf_we      = r_rf_we;
    assign bus.wb_sel     = r_wb_sel;
    assign bus.alu_op     = r_alu_op;
    assign bus.halted     = r_halted;
    assign bus.illegal    = r_illegal;
    assign bus.addr_src   = RF_AW'(r_ir[RS_MSB:RS_LSB]);
    assign bus.addr_tmp   = RF_AW'(r_ir[RT_MSB:RT_LSB]);
    assign bus.addr_dest  = RF_AW'(r_ir[RD_MSB:RD_LSB]);
    assign bus.imm_out    = r_ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: small ROM model, hand-computed expectations.
// Latency: n/a.
// Backpressure: bench drives mem_ack and alu_zero directly.
module tb_cpu_ctrl_fsm;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic [15:0] rom [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    cpu_ctrl_fsm_if #(.PC_W(10), .RF_AW(4)) bus ();

    cpu_ctrl_fsm #(.PC_W(10), .RF_AW(4)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    assign bus.instr_in = rom[bus.addr_instr];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int n_req;
        int n_hold;
        logic we_seen;

        bus.alu_zero = 1'b0;
        bus.mem_ack  = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = 16'hC000;
        rom[0]    = 16'h0123;  // ADD r1 = r3 + r2
        rom[1]    = 16'h8405;  // LD  r4 = mem[r5]
        rom[2]    = 16'h9067;  // ST  mem[r7] = r6
        rom[3]    = 16'h72AB;  // LI  r2 = 0xAB
        rom[4]    = 16'h1234;  // SUB r2 = r4 - r3
        rom[5]    = 16'hAE12;  // BEQ r2,r1, -2
        rom[6]    = 16'hD000;  // undefined
        rom[7]    = 16'hB3FF;  // JMP 0x3FF
        rom[1023] = 16'hC000;  // NOP

        // ---- reset state
        #12;
        chk("rst_addr_instr", 32'(bus.addr_instr), 0);
        chk("rst_mem_req",    32'(bus.mem_req), 0);
        chk("rst_mem_we",     32'(bus.mem_we), 0);
        chk("rst_rf_we",      32'(bus.rf_we), 0);
        chk("rst_wb_sel",     32'(bus.wb_sel), 0);
        chk("rst_alu_op",     32'(bus.alu_op), 0);
        chk("rst_halted",     32'(bus.halted), 0);
        chk("rst_illegal",    32'(bus.illegal), 0);
        chk("rst_addr_dest",  32'(bus.addr_dest), 0);
        sys_rst = 1'b1;

        // ---- ADD at PC 0
        chk("add_fetch_addr", 32'(bus.addr_instr), 0);
        tick();
        chk("add_dec_addr", 32'(bus.addr_instr), 0);
        tick();
        chk("add_exec_addr", 32'(bus.addr_instr), 1);
        chk("add_exec_alu_op", 32'(bus.alu_op), 0);
        chk("add_exec_rf_we", 32'(bus.rf_we), 0);
        chk("add_addr_src", 32'(bus.addr_src), 3);
        chk("add_addr_tmp", 32'(bus.addr_tmp), 2);
        tick();
        chk("add_wb_rf_we", 32'(bus.rf_we), 1);
        chk("add_wb_dest", 32'(bus.addr_dest), 1);
        chk("add_wb_sel", 32'(bus.wb_sel), 0);
        rom[0] = 16'hF000;  // HALT when PC later wraps to 0
        tick();
        chk("add_after_rf_we", 32'(bus.rf_we), 0);
        chk("ld_fetch_addr", 32'(bus.addr_instr), 1);

        // ---- LD with ack in the third MEM cycle
        tick();
        tick();
        chk("ld_exec_alu_op", 32'(bus.alu_op), 0);
        chk("ld_exec_req", 32'(bus.mem_req), 0);
        chk("ld_addr_src", 32'(bus.addr_src), 5);
        n_req = 0;
        we_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.mem_req !== 1'b1) break;
            n_req++;
            we_seen = we_seen | bus.mem_we;
            if (n_req == 3) bus.mem_ack = 1'b1;
        end
        bus.mem_ack = 1'b0;
        chk("ld_req_cycles", 32'(n_req), 3);
        chk("ld_mem_we", 32'(we_seen), 0);
        chk("ld_wb_rf_we", 32'(bus.rf_we), 1);
        chk("ld_wb_sel", 32'(bus.wb_sel), 1);
        chk("ld_wb_dest", 32'(bus.addr_dest), 4);
        tick();
        chk("st_fetch_addr", 32'(bus.addr_instr), 2);

        // ---- ST with ack in the first MEM cycle
        tick();
        tick();
        tick();
        chk("st_mem_req", 32'(bus.mem_req), 1);
        chk("st_mem_we", 32'(bus.mem_we), 1);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("st_req_drop", 32'(bus.mem_req), 0);
        chk("st_no_rf_we", 32'(bus.rf_we), 0);
        chk("st_next_fetch", 32'(bus.addr_instr), 3);

        // ---- LI
        tick();
        chk("li_dec_rf_we", 32'(bus.rf_we), 0);
        tick();
        chk("li_wb_rf_we", 32'(bus.rf_we), 1);
        chk("li_wb_sel", 32'(bus.wb_sel), 2);
        chk("li_imm", 32'(bus.imm_out), 32'hAB);
        chk("li_dest", 32'(bus.addr_dest), 2);
        tick();
        chk("sub_fetch_addr", 32'(bus.addr_instr), 4);

        // ---- SUB
        tick();
        tick();
        chk("sub_exec_alu_op", 32'(bus.alu_op), 1);
        tick();
        chk("sub_wb_alu_op_hold", 32'(bus.alu_op), 1);
        chk("sub_wb_rf_we", 32'(bus.rf_we), 1);
        tick();
        chk("beq_fetch_addr", 32'(bus.addr_instr), 5);

        // ---- BEQ taken (offset -2 from PC+1)
        tick();
        tick();
        chk("beq_exec_alu_op", 32'(bus.alu_op), 1);
        chk("beq_exec_addr", 32'(bus.addr_instr), 6);
        bus.alu_zero = 1'b1;
        tick();
        bus.alu_zero = 1'b0;
        chk("beq_taken", 32'(bus.addr_instr), 4);
        tick();
        tick();
        tick();
        tick();
        chk("beq2_fetch_addr", 32'(bus.addr_instr), 5);
        tick();
        tick();
        tick();
        chk("beq_not_taken", 32'(bus.addr_instr), 6);

        // ---- undefined opcode D
        chk("ill_before", 32'(bus.illegal), 0);
        tick();
        tick();
        chk("ill_set", 32'(bus.illegal), 1);
        chk("ill_next_pc", 32'(bus.addr_instr), 7);

        // ---- JMP 0x3FF then NOP wraps PC
        tick();
        tick();
        chk("jmp_target", 32'(bus.addr_instr), 32'h3FF);
        chk("ill_sticky", 32'(bus.illegal), 1);
        tick();
        tick();
        chk("pc_wrap", 32'(bus.addr_instr), 0);

        // ---- HALT
        tick();
        tick();
        chk("halt_flag", 32'(bus.halted), 1);
        chk("halt_addr", 32'(bus.addr_instr), 1);
        n_hold = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.addr_instr === 10'd1 && bus.halted === 1'b1 &&
                bus.rf_we === 1'b0 && bus.mem_req === 1'b0) n_hold++;
        end
        chk("halt_hold_cycles", 32'(n_hold), 20);

        // ---- reset out of HALT, with a stale ack present
        rom[0] = 16'h8405;  // LD
        #2;
        sys_rst = 1'b0;
        bus.mem_ack = 1'b1;
        #1;
        chk("rst2_halted", 32'(bus.halted), 0);
        chk("rst2_illegal", 32'(bus.illegal), 0);
        chk("rst2_addr", 32'(bus.addr_instr), 0);
        #2;
        sys_rst = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        chk("rst2_exec_req", 32'(bus.mem_req), 0);
        chk("rst2_exec_addr", 32'(bus.addr_instr), 1);
        tick();
        chk("rst2_mem1_req", 32'(bus.mem_req), 1);
        tick();
        chk("rst2_mem2_req", 32'(bus.mem_req), 1);

        // ---- reset mid-MEM drops mem_req without a clock edge
        #3;
        sys_rst = 1'b0;
        #1;
        chk("rst3_req_async", 32'(bus.mem_req), 0);
        chk("rst3_we_async", 32'(bus.mem_we), 0);
        #1;
        sys_rst = 1'b1;
        chk("rst3_addr", 32'(bus.addr_instr), 0);
        tick();
        chk("rst3_dec_addr", 32'(bus.addr_instr), 0);
        chk("rst3_dec_req", 32'(bus.mem_req), 0);
        tick();
        chk("rst3_exec_addr", 32'(bus.addr_instr), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control sequencer for the 16-bit-instruction / 32-bit-data CPU core. It owns the PC and the instruction register (IR). It decodes each instruction and drives the register-file address, write-enable and write-back select, the ALU opcode and the data-memory handshake. It sits in cpu_top between instruction memory and the register_file/ALU datapath.

Parameters:
PC_W, 10, instruction address width (matches addr_instr)
RF_AW, 4, register-file address width

Ports:
sys_clk  in  1  core clock, rising edge
sys_rst  in  1  asynchronous, active-low reset
instr_in  in  16  instruction memory read data; valid the cycle after addr_instr changes
addr_instr  out  PC_W  instruction fetch address (current PC)
alu_zero  in  1  ALU result-is-zero flag, combinational from current alu_op and operands
mem_ack  in  1  data memory done; single-cycle pulse
mem_req  out  1  data memory request; level, held until ack
mem_we  out  1  1 = store, 0 = load; valid while mem_req=1
addr_src  out  RF_AW  register-file source address (IR[3:0])
addr_tmp  out  RF_AW  register-file temp address (IR[7:4])
addr_dest  out  RF_AW  register-file destination address (IR[11:8])
rf_we  out  1  register-file write enable; one-cycle pulse in WB
wb_sel  out  2  write-back mux select: 00 ALU, 01 memory data, 10 immediate
imm_out  out  8  zero-extended immediate IR[7:0] for LI
alu_op  out  4  ALU operation code
halted  out  1  core stopped by HALT
illegal  out  1  sticky: an undefined opcode was decoded

Behaviour:
- Instruction format: op = IR[15:12], rd = IR[11:8], rt = IR[7:4], rs = IR[3:0].
- Opcodes:
  - 0-6: ADD SUB AND OR XOR SHL SHR, rd <= rs op rt.
  - 7: LI, rd <= IR[7:0].
  - 8: LD, rd <= mem[rs].
  - 9: ST, mem[rs] <= rt.
  - A: BEQ, if rs==rt then PC <= PC + sext(IR[11:8]).
  - B: JMP, PC <= IR[9:0].
  - C: NOP.
  - F: HALT.
  - D, E: undefined.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset (async, sys_rst=0):
  - State = FETCH; PC = 0; IR = 16'h C000 (NOP).
  - All outputs 0: mem_req, mem_we, rf_we, wb_sel, alu_op, halted, illegal.
  - An in-flight mem_req drops immediately; any pending ack after reset is ignored.
- FETCH: addr_instr = PC, go to DECODE.
- DECODE:
  - IR <= instr_in; PC <= PC+1, wrapping 1023 -> 0.
  - Next state by opcode:
    - ALU ops, LD, ST, BEQ -> EXEC.
    - LI -> WB.
    - JMP -> FETCH, with PC <= IR[9:0]; JMP overrides the increment.
    - NOP -> FETCH.
    - HALT -> HALT.
    - Undefined -> FETCH, set illegal.
- EXEC:
  - alu_op = op for ALU ops; ADD (0) for LD/ST; SUB (1) for BEQ.
  - BEQ: if alu_zero=1, PC <= PC + sign-extended IR[11:8] (PC already incremented), modulo 2^PC_W; then FETCH.
  - LD/ST -> MEM; ALU ops -> WB.
- MEM:
  - mem_req=1, mem_we = (op==ST).
  - Stay in MEM until mem_ack=1; ack in the first MEM cycle is legal (1-cycle access).
  - On ack: LD -> WB; ST -> FETCH. mem_req deasserts on the next edge.
  - No timeout.
- WB:
  - rf_we=1 for exactly one cycle.
  - wb_sel = 00 for ALU ops, 01 for LD, 10 for LI.
  - Then FETCH.
- HALT: halted=1, all enables 0, PC frozen; exit only via reset.
- addr_src, addr_tmp and addr_dest are driven combinationally from IR in every state.
- alu_op holds its value through WB so the ALU result stays stable at write time.
- Cycle counts: ALU op 4; LI 3; LD 5+wait; ST 4+wait; BEQ 3; JMP/NOP 2.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants (OP_ADD..OP_HALT).
  - State encodings.
  - wb_sel encodings (WB_ALU, WB_MEM, WB_IMM).
  - Field bit positions.
- One natural sub-module: cpu_decoder. It is combinational: opcode in, next-state class, alu_op, wb_sel, mem_we and illegal out. The FSM, PC and IR stay in cpu_ctrl_fsm.

Test Plan:
- Reset then ROM[0]=16'h0123 (ADD r1 = r3 + r2): addr_instr = 0 then 1; alu_op=0 in EXEC; rf_we pulses in cycle 4 with addr_dest=1, wb_sel=00.
- LD with mem_ack delayed 3 cycles: mem_req high for exactly 3 MEM cycles, mem_we=0; rf_we at the following WB with wb_sel=01. ST with ack in the first MEM cycle: mem_we=1, returns to FETCH with no rf_we pulse.
- BEQ at PC=5, IR[11:8]=4'hE (-2), alu_zero=1: next fetch address = 4. Same instruction with alu_zero=0: next fetch address = 6.
- JMP 10'h3FF followed by NOP: fetch at 1023, then PC wraps to 0.
- Opcode D: illegal=1 and stays 1; execution continues at the next PC. HALT: halted=1 and addr_instr stays constant for 20 cycles.
- sys_rst asserted mid-MEM (mem_req=1, no ack): mem_req drops asynchronously. After release: PC=0, state FETCH, illegal and halted cleared.
